// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel divider, x/y counters, registered sync/blank/strobes.
// Ports: clk, reset (sync, active-high) in; x, y, hsync, vsync, blank_n, pix_en, frame_tick out;
// frame_cnt out only when VGA_TIMING_FRAME_CNT_EN is defined.
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic        pix_en,
    output logic        frame_tick
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] V_PRE    = 10'(V_ACTIVE - 1);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic       SYNC_ON  = (SYNC_POL != 0);

    logic [3:0] div_cnt;
    logic [3:0] div_nxt;
    logic [9:0] x_nxt;
    logic [9:0] y_nxt;
    logic       adv;
    logic       h_wrap;
    logic       hs_nxt;
    logic       vs_nxt;
    logic       bn_nxt;
    logic       pe_nxt;
    logic       ft_nxt;

    // Flags are decoded from the next counter values so that, once
    // registered, they line up with x/y in the same cycle.
    always_comb begin
        adv     = (div_cnt == DIV_LAST);
        h_wrap  = (x == H_LAST);
        div_nxt = adv ? 4'd0 : div_cnt + 4'd1;
        x_nxt   = x;
        y_nxt   = y;
        if (adv) begin
            x_nxt = h_wrap ? 10'd0 : x + 10'd1;
            if (h_wrap) begin
                y_nxt = (y == V_LAST) ? 10'd0 : y + 10'd1;
            end
        end
        hs_nxt = (x_nxt >= HS_FIRST && x_nxt <= HS_LAST) ? SYNC_ON : ~SYNC_ON;
        vs_nxt = (y_nxt >= VS_FIRST && y_nxt <= VS_LAST) ? SYNC_ON : ~SYNC_ON;
        bn_nxt = (x_nxt < H_VIS) && (y_nxt < V_VIS);
        pe_nxt = (div_nxt == DIV_LAST);
        // Only a real line wrap into the first blanking line raises the tick;
        // reset lands on (0,0) and can never produce it.
        ft_nxt = adv && h_wrap && (y == V_PRE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt    <= 4'd0;
            x          <= 10'd0;
            y          <= 10'd0;
            hsync      <= ~SYNC_ON;
            vsync      <= ~SYNC_ON;
            blank_n    <= 1'b1;
            pix_en     <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            div_cnt    <= div_nxt;
            x          <= x_nxt;
            y          <= y_nxt;
            hsync      <= hs_nxt;
            vsync      <= vs_nxt;
            blank_n    <= bn_nxt;
            pix_en     <= pe_nxt;
            frame_tick <= ft_nxt;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= 16'd0;
        end else if (ft_nxt) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Free-running VGA raster timing generator that produces the pixel coordinates, sync pulses, blanking flag and per-frame strobe for the display pipeline. It sits directly upstream of the sprite renderers such as the spaceship: they consume `x`/`y` to decide pixel colour, and `frame_tick` is their once-per-frame movement sample strobe. This replaces per-sprite 60 Hz dividers. Default parameters give 640x480@60 Hz from a 50 MHz `clk`.

## Interface
- `CLK_DIV`, 2: `clk` cycles per pixel; legal range 1..16.
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: hsync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vsync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `SYNC_POL`, 0: sync active level; 0 = active-low.

Ports:
- `clk`  in  1: single system clock; all logic on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `x`  out  10: current pixel column, 0..H_TOTAL-1.
- `y`  out  10: current line, 0..V_TOTAL-1.
- `hsync`  out  1: horizontal sync, level per `SYNC_POL`.
- `vsync`  out  1: vertical sync, level per `SYNC_POL`.
- `blank_n`  out  1: 1 when (`x`,`y`) is in the visible region.
- `pix_en`  out  1: one-`clk` strobe marking the last cycle of each pixel.
- `frame_tick`  out  1: one-`clk` pulse at the start of vertical blanking.
- `frame_cnt`  out  16: frame counter; port exists only with `VGA_TIMING_FRAME_CNT_EN`.

## Operation
- Derived totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
  - Both totals must be ≤1024. Out-of-range parameters are unsupported; no checking logic is required.
- Divider: `div_cnt` counts 0..CLK_DIV-1 and wraps. The advance condition is `div_cnt`==CLK_DIV-1.
- Horizontal counter: `x` increments on each advance. At H_TOTAL-1 it wraps to 0.
- Vertical counter: `y` increments only when `x` wraps. At V_TOTAL-1 it wraps to 0, on the same edge that `x` wraps.
- Decoded outputs are registered and computed from the next counter values, so they are aligned with `x`/`y` in the same cycle:
  - `hsync` is active while `x` ∈ [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751 by default).
  - `vsync` is active while `y` ∈ [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491 by default).
  - `blank_n` = (`x`<H_ACTIVE) && (`y`<V_ACTIVE).
- `pix_en` is high in the final `clk` cycle of each pixel, so downstream logic samples `x`/`y` when `pix_en`=1.
- `frame_tick` is high for exactly one `clk` cycle: the first cycle in which (`x`,`y`) = (0,V_ACTIVE).

## Timing
- Reset values, one edge after `reset` is sampled high:
  - `x`=0, `y`=0, `div_cnt`=0.
  - `blank_n`=1, because (0,0) is visible.
  - `hsync`=`vsync`=inactive (1 when SYNC_POL=0).
  - `pix_en`=0, `frame_tick`=0, `frame_cnt`=0.
- After reset release:
  - Each pixel lasts exactly CLK_DIV `clk` cycles.
  - One line lasts H_TOTAL·CLK_DIV cycles (1600 by default).
  - One frame lasts V_TOTAL·H_TOTAL·CLK_DIV cycles (840000 by default).
- Pixel (0,0) after reset is held for CLK_DIV cycles, the same as every other pixel.
- `pix_en` first asserts in cycle CLK_DIV after reset release.
- CLK_DIV=1: `pix_en`=1 in every non-reset cycle, and the counters advance every edge.
- Reset mid-operation overrides all state at the next edge. There is no partial line or frame completion, and no `frame_tick` is generated by the reset.
- Double wrap: at (H_TOTAL-1, V_TOTAL-1) with an advance, both counters return to 0 on the same edge. No other output glitches at that edge.
- Output latency: 0 cycles between the counters and the decoded flags; all are registered on the same edge.

## Configuration
- `VGA_TIMING_FRAME_CNT_EN` defined:
  - `frame_cnt[15:0]` port and register exist.
  - It increments on the edge that raises `frame_tick` and wraps 65535→0.
  - It resets to 0.
- Not defined: no port and no register. All other behaviour is identical.

## Test plan
- Reset: hold `reset` 3 cycles, then release. Required: `x`=0, `y`=0, `blank_n`=1, `hsync`=`vsync`=1, `pix_en`=0, and first `pix_en` at cycle 2 (CLK_DIV=2).
- Line timing: run one line. Required: `x` steps every 2 clks; `hsync` low for exactly 192 clks while `x`=656..751; `blank_n` falls at the transition `x`=639→640; `x` wraps 799→0 as `y` increments.
- Frame timing: run 2 frames. Required:
  - `vsync` low only for `y`=490..491 (3200 clks).
  - `blank_n`=0 for all `y`≥480.
  - `frame_tick` pulses once per 840000 clks, exactly when (`x`,`y`)=(0,480).
- Double wrap: at (799,524) with `pix_en`=1. Required: next edge (0,0), `blank_n`=1, no `frame_tick`.
- Mid-frame reset at (300,200). Required: next edge all reset values, and the following frame is full length.
- CLK_DIV=1 and `VGA_TIMING_FRAME_CNT_EN` defined; run 3 frames. Required: `pix_en` constant 1, `frame_cnt` reads 1, 2, 3 after the respective `frame_tick`s.
